// File: rtl/coin_change_dispenser_if.sv
// Handshake bundle between the vending controller, coin hopper and dispenser.
// The slave side is the dispenser; the master side drives request and ack.
interface coin_change_dispenser_if #(
  parameter int TOTAL_BITS = 31
);
  logic                  i_return_req;
  logic [TOTAL_BITS-1:0] i_total;
  logic                  i_coin_ack;
  logic                  o_busy;
  logic                  o_coin_valid;
  logic [2:0]            o_coin_sel;
  logic [TOTAL_BITS-1:0] o_remaining;
  logic [TOTAL_BITS-1:0] o_dispensed;
  logic                  o_done;
  logic                  o_fault;

  modport master (
    output i_return_req, i_total, i_coin_ack,
    input  o_busy, o_coin_valid, o_coin_sel,
    input  o_remaining, o_dispensed, o_done, o_fault
  );

  modport slave (
    input  i_return_req, i_total, i_coin_ack,
    output o_busy, o_coin_valid, o_coin_sel,
    output o_remaining, o_dispensed, o_done, o_fault
  );
endinterface

// File: rtl/coin_change_dispenser.sv
// Greedy coin payout: latches the balance and hands coins to the hopper
// one at a time, largest first, with a per-coin ack timeout.
module coin_change_dispenser #(
  parameter int TOTAL_BITS  = 31,
  parameter int COIN0_VAL   = 100,
  parameter int COIN1_VAL   = 500,
  parameter int COIN2_VAL   = 1000,
  parameter int ACK_TIMEOUT = 16
) (
  input logic                    clk,
  input logic                    reset_n,
  coin_change_dispenser_if.slave bus
);

  localparam int CW =
    (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

  localparam logic [TOTAL_BITS-1:0] C0 =
    TOTAL_BITS'(COIN0_VAL);
  localparam logic [TOTAL_BITS-1:0] C1 =
    TOTAL_BITS'(COIN1_VAL);
  localparam logic [TOTAL_BITS-1:0] C2 =
    TOTAL_BITS'(COIN2_VAL);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SELECT,
    DISPENSE,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  valid_q, valid_d;
  logic [2:0]            sel_q, sel_d;
  logic [TOTAL_BITS-1:0] rem_q, rem_d;
  logic [TOTAL_BITS-1:0] disp_q, disp_d;
  logic                  done_q, done_d;
  logic                  fault_q, fault_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [TOTAL_BITS-1:0] coin_val;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      sel_q   <= '0;
      rem_q   <= '0;
      disp_q  <= '0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      sel_q   <= sel_d;
      rem_q   <= rem_d;
      disp_q  <= disp_d;
      done_q  <= done_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    coin_val = '0;
    unique case (1'b1)
      sel_q[2]: coin_val = C2;
      sel_q[1]: coin_val = C1;
      sel_q[0]: coin_val = C0;
      default:  coin_val = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    sel_d   = sel_q;
    rem_d   = rem_q;
    disp_d  = disp_q;
    fault_d = fault_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.i_return_req) begin
          rem_d   = bus.i_total;
          disp_d  = '0;
          fault_d = 1'b0;
          state_d = SELECT;
        end
      end
      SELECT: begin
        cnt_d = '0;
        if (rem_q >= C2) begin
          sel_d   = 3'b100;
          valid_d = 1'b1;
          state_d = DISPENSE;
        end else if (rem_q >= C1) begin
          sel_d   = 3'b010;
          valid_d = 1'b1;
          state_d = DISPENSE;
        end else if (rem_q >= C0) begin
          sel_d   = 3'b001;
          valid_d = 1'b1;
          state_d = DISPENSE;
        end else begin
          state_d = DONE;
        end
      end
      DISPENSE: begin
        // ack wins over a timeout expiring on the same edge
        if (bus.i_coin_ack) begin
          rem_d   = rem_q - coin_val;
          disp_d  = disp_q + coin_val;
          valid_d = 1'b0;
          sel_d   = '0;
          state_d = SELECT;
        end else if (cnt_q == CNT_LAST) begin
          fault_d = 1'b1;
          valid_d = 1'b0;
          sel_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_coin_valid = valid_q;
  assign bus.o_coin_sel   = sel_q;
  assign bus.o_remaining  = rem_q;
  assign bus.o_dispensed  = disp_q;
  assign bus.o_done       = done_q;
  assign bus.o_fault      = fault_q;

endmodule
